// File: rtl/matrix_storage_server.sv
// Shared word-addressed matrix store: fixed two-edge read pipeline, two prioritised
// write ports, and a zero-fill sweep after reset or on request.
module matrix_storage_server #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_calc_we,
    input  logic [ADDR_W-1:0] i_calc_waddr,
    input  logic [DATA_W-1:0] i_calc_wdata,
    input  logic              i_in_we,
    input  logic [ADDR_W-1:0] i_in_waddr,
    input  logic [DATA_W-1:0] i_in_wdata,
    input  logic              i_clear,
    output logic              o_ready,
    output logic              o_wr_conflict,
    output logic              o_addr_err
);

    // state   | meaning
    // S_CLEAR | sweep writes 0 to mem[sweep_cnt_q]; user writes ignored
    // S_READY | normal operation, arbitrated user writes accepted
    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] sweep_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              conflict_q;
    logic              err_q;

    logic [DATA_W-1:0] rdata_d;
    logic              rd_err_d;
    logic              wr_err_d;
    logic              conflict_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              calc_ok;
    logic              in_ok;

    always_comb begin
        rd_err_d   = ({1'b0, addr_q} >= DEPTH_X);
        rdata_d    = rd_err_d ? '0 : mem[addr_q];
        calc_ok    = ({1'b0, i_calc_waddr} < DEPTH_X);
        in_ok      = ({1'b0, i_in_waddr} < DEPTH_X);
        wr_en_d    = 1'b0;
        wr_addr_d  = sweep_cnt_q;
        wr_data_d  = '0;
        conflict_d = 1'b0;
        wr_err_d   = 1'b0;
        if (state_q == S_CLEAR) begin
            wr_en_d = 1'b1;
        end else if (i_calc_we) begin
            // the losing input write is dropped silently apart from the conflict pulse
            conflict_d = i_in_we;
            if (calc_ok) begin
                wr_en_d   = 1'b1;
                wr_addr_d = i_calc_waddr;
                wr_data_d = i_calc_wdata;
            end else begin
                wr_err_d = 1'b1;
            end
        end else if (i_in_we) begin
            if (in_ok) begin
                wr_en_d   = 1'b1;
                wr_addr_d = i_in_waddr;
                wr_data_d = i_in_wdata;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Array has no reset; read-first falls out of the non-blocking update.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[wr_addr_d] <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            sweep_cnt_q <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            conflict_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            addr_q     <= i_raddr;
            rdata_q    <= rdata_d;
            conflict_q <= conflict_d;
            err_q      <= rd_err_d | wr_err_d;
            case (state_q)
                S_CLEAR: begin
                    if (i_clear) begin
                        sweep_cnt_q <= '0;
                    end else if (sweep_cnt_q == LAST_ADDR) begin
                        sweep_cnt_q <= '0;
                        state_q     <= S_READY;
                    end else begin
                        sweep_cnt_q <= sweep_cnt_q + ADDR_W'(1);
                    end
                end
                S_READY: begin
                    if (i_clear) begin
                        sweep_cnt_q <= '0;
                        state_q     <= S_CLEAR;
                    end
                end
                default: begin
                    sweep_cnt_q <= '0;
                    state_q     <= S_CLEAR;
                end
            endcase
        end
    end

    assign o_ready       = (state_q == S_READY);
    assign o_rdata       = rdata_q;
    assign o_wr_conflict = conflict_q;
    assign o_addr_err    = err_q;

endmodule

// File: tb/tb_matrix_storage_server.sv
// Bench for matrix_storage_server: a DEPTH=256 and a DEPTH=200 instance share
// stimulus and are compared against an array-based reference model.
module tb_matrix_storage_server;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] raddr;
    logic          calc_we;
    logic [AW-1:0] calc_waddr;
    logic [DW-1:0] calc_wdata;
    logic          in_we;
    logic [AW-1:0] in_waddr;
    logic [DW-1:0] in_wdata;
    logic          clr;

    logic [DW-1:0] rdata_w [2];
    logic          ready_w [2];
    logic          conf_w  [2];
    logic          err_w   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matrix_storage_server #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_w[0]),
        .i_calc_we(calc_we), .i_calc_waddr(calc_waddr), .i_calc_wdata(calc_wdata),
        .i_in_we(in_we), .i_in_waddr(in_waddr), .i_in_wdata(in_wdata),
        .i_clear(clr), .o_ready(ready_w[0]), .o_wr_conflict(conf_w[0]), .o_addr_err(err_w[0])
    );

    matrix_storage_server #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_w[1]),
        .i_calc_we(calc_we), .i_calc_waddr(calc_waddr), .i_calc_wdata(calc_wdata),
        .i_in_we(in_we), .i_in_waddr(in_waddr), .i_in_wdata(in_wdata),
        .i_clear(clr), .o_ready(ready_w[1]), .o_wr_conflict(conf_w[1]), .o_addr_err(err_w[1])
    );

    function automatic int depth_of(int k);
        return (k == 0) ? 256 : 200;
    endfunction

    // Reference model: memory contents, sweep cycles remaining, and the expected
    // value of every registered output after the most recent edge.
    logic [DW-1:0] m_mem [2][256];
    int            m_left [2];
    int            m_apipe [2];
    logic [DW-1:0] exp_rdata [2];
    bit            exp_valid [2];
    bit            exp_conf [2];
    bit            exp_err [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            int d;
            bit rdy;
            d = depth_of(k);
            if (!rst_n) begin
                for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
                m_left[k]    = d;
                m_apipe[k]   = 0;
                exp_rdata[k] = '0;
                exp_valid[k] = 1'b1;
                exp_conf[k]  = 1'b0;
                exp_err[k]   = 1'b0;
            end else begin
                rdy          = (m_left[k] == 0);
                exp_valid[k] = rdy;
                exp_rdata[k] = (m_apipe[k] < d) ? m_mem[k][m_apipe[k]] : '0;
                exp_err[k]   = (m_apipe[k] >= d);
                exp_conf[k]  = 1'b0;
                m_apipe[k]   = int'(raddr);
                if (rdy) begin
                    if (calc_we) begin
                        exp_conf[k] = in_we;
                        if (int'(calc_waddr) < d) m_mem[k][calc_waddr] = calc_wdata;
                        else exp_err[k] = 1'b1;
                    end else if (in_we) begin
                        if (int'(in_waddr) < d) m_mem[k][in_waddr] = in_wdata;
                        else exp_err[k] = 1'b1;
                    end
                    if (clr) begin
                        for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
                        m_left[k] = d;
                    end
                end else begin
                    m_left[k] = clr ? d : m_left[k] - 1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        calc_we = 1'b0;
        in_we   = 1'b0;
        clr     = 1'b0;
    endtask

    // Counts edges until each instance raises o_ready; optionally hammers both
    // write ports while the sweep is still running on both.
    task automatic wait_ready(input bit do_writes, output int c0, output int c1, output bit saw_conf);
        int n;
        n = 0; c1 = 0; saw_conf = 1'b0;
        while (!ready_w[0] && n < 400) begin
            if (do_writes && !ready_w[1]) begin
                calc_we    = 1'b1;
                calc_waddr = AW'($urandom_range(0, 199));
                calc_wdata = $urandom | 32'h1;
                in_we      = 1'b1;
                in_waddr   = AW'($urandom_range(0, 199));
                in_wdata   = $urandom | 32'h1;
            end else begin
                idle();
            end
            @(posedge clk);
            #1;
            n++;
            if (conf_w[0] || conf_w[1]) saw_conf = 1'b1;
            if (ready_w[1] && c1 == 0) c1 = n;
        end
        c0 = n;
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int c0, c1;
        bit sc;
        rst_n = 1'b0;
        idle();
        raddr = '0; calc_waddr = '0; calc_wdata = '0; in_waddr = '0; in_wdata = '0;
        #23;
        for (int k = 0; k < 2; k++) begin
            n_checks += 4;
            if (ready_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, ready_w[k]); end
            if (rdata_w[k] !== '0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", k, rdata_w[k]); end
            if (conf_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_conflict[%0d]: got %b expected 0", k, conf_w[k]); end
            if (err_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err[%0d]: got %b expected 0", k, err_w[k]); end
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ready(1'b0, c0, c1, sc);
        n_checks += 2;
        if (c0 != 256) begin n_fail++; $display("FAIL reset_sweep_len0: got %0d edges expected 256", c0); end
        if (c1 != 200) begin n_fail++; $display("FAIL reset_sweep_len1: got %0d edges expected 200", c1); end
        for (int i = 0; i <= 256; i++) begin
            raddr = AW'(i % 256);
            tick();
            if (i >= 1) begin
                n_checks += 3;
                if (rdata_w[0] !== '0) begin n_fail++; $display("FAIL reset_zero0 addr %0d: got %h expected 0", i-1, rdata_w[0]); end
                if (rdata_w[1] !== '0) begin n_fail++; $display("FAIL reset_zero1 addr %0d: got %h expected 0", i-1, rdata_w[1]); end
                if (err_w[1] !== ((i-1) >= 200)) begin n_fail++; $display("FAIL reset_rd_err1 addr %0d: got %b expected %b", i-1, err_w[1], (i-1) >= 200); end
            end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] vals [25];
        calc_we = 1'b1; calc_waddr = 8'd5; calc_wdata = 32'h0000_0007;
        tick();
        idle(); raddr = 8'd5;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rdata_w[k] !== 32'h7) begin n_fail++; $display("FAIL wr_rd_addr5[%0d]: got %h expected 00000007", k, rdata_w[k]); end
        end
        for (int i = 0; i < 25; i++) begin
            vals[i] = $urandom;
            idle();
            if (i % 2 == 0) begin
                calc_we = 1'b1; calc_waddr = AW'(i); calc_wdata = vals[i];
            end else begin
                in_we = 1'b1; in_waddr = AW'(i); in_wdata = vals[i];
            end
            tick();
        end
        idle();
        for (int i = 0; i <= 25; i++) begin
            raddr = AW'(i);
            tick();
            if (i >= 1) begin
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (rdata_w[k] !== vals[i-1]) begin n_fail++; $display("FAIL burst[%0d] addr %0d: got %h expected %h", k, i-1, rdata_w[k], vals[i-1]); end
                end
            end
        end
    endtask

    task automatic test_conflict();
        calc_we = 1'b1; calc_waddr = 8'd10; calc_wdata = 32'hAA;
        in_we   = 1'b1; in_waddr   = 8'd10; in_wdata   = 32'hBB;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (conf_w[k] !== 1'b1) begin n_fail++; $display("FAIL conflict_pulse[%0d]: got %b expected 1", k, conf_w[k]); end
        end
        raddr = 8'd10;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (conf_w[k] !== 1'b0) begin n_fail++; $display("FAIL conflict_width[%0d]: got %b expected 0", k, conf_w[k]); end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rdata_w[k] !== 32'hAA) begin n_fail++; $display("FAIL conflict_winner[%0d]: got %h expected 000000aa", k, rdata_w[k]); end
        end
        in_we = 1'b1; in_waddr = 8'd11; in_wdata = 32'hCC;
        tick();
        idle(); raddr = 8'd11;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (conf_w[k] !== 1'b0) begin n_fail++; $display("FAIL input_alone_conflict[%0d]: got %b expected 0", k, conf_w[k]); end
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rdata_w[k] !== 32'hCC) begin n_fail++; $display("FAIL input_alone_data[%0d]: got %h expected 000000cc", k, rdata_w[k]); end
        end
    endtask

    task automatic test_read_during_write();
        logic [DW-1:0] old_w;
        old_w = 32'h1234_5678;
        calc_we = 1'b1; calc_waddr = 8'd12; calc_wdata = old_w;
        tick();
        idle(); raddr = 8'd12;
        tick();
        calc_we = 1'b1; calc_waddr = 8'd12; calc_wdata = 32'h55;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rdata_w[k] !== old_w) begin n_fail++; $display("FAIL rdw_old[%0d]: got %h expected %h", k, rdata_w[k], old_w); end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rdata_w[k] !== 32'h55) begin n_fail++; $display("FAIL rdw_new[%0d]: got %h expected 00000055", k, rdata_w[k]); end
        end
    endtask

    task automatic test_clear();
        int c0, c1;
        bit sc;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (ready_w[k] !== 1'b0) begin n_fail++; $display("FAIL clear_ready_fall[%0d]: got %b expected 0", k, ready_w[k]); end
        end
        wait_ready(1'b1, c0, c1, sc);
        n_checks += 3;
        if (c0 != 256) begin n_fail++; $display("FAIL clear_len0: got %0d edges expected 256", c0); end
        if (c1 != 200) begin n_fail++; $display("FAIL clear_len1: got %0d edges expected 200", c1); end
        if (sc !== 1'b0) begin n_fail++; $display("FAIL clear_conflict: got %b expected 0", sc); end
        for (int i = 0; i <= 256; i++) begin
            raddr = AW'(i % 256);
            tick();
            if (i >= 1) begin
                n_checks += 2;
                if (rdata_w[0] !== '0) begin n_fail++; $display("FAIL clear_zero0 addr %0d: got %h expected 0", i-1, rdata_w[0]); end
                if (rdata_w[1] !== '0) begin n_fail++; $display("FAIL clear_zero1 addr %0d: got %h expected 0", i-1, rdata_w[1]); end
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (50) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wait_ready(1'b0, c0, c1, sc);
        n_checks += 2;
        if (c0 != 256) begin n_fail++; $display("FAIL restart_len0: got %0d edges expected 256", c0); end
        if (c1 != 200) begin n_fail++; $display("FAIL restart_len1: got %0d edges expected 200", c1); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (100) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (ready_w[k] !== 1'b0) begin n_fail++; $display("FAIL midsweep_rst_ready[%0d]: got %b expected 0", k, ready_w[k]); end
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ready(1'b0, c0, c1, sc);
        n_checks += 2;
        if (c0 != 256) begin n_fail++; $display("FAIL midsweep_rst_len0: got %0d edges expected 256", c0); end
        if (c1 != 200) begin n_fail++; $display("FAIL midsweep_rst_len1: got %0d edges expected 200", c1); end
    endtask

    task automatic test_addr_err();
        raddr = 8'd250;
        tick();
        raddr = 8'd0;
        tick();
        n_checks += 4;
        if (rdata_w[1] !== '0) begin n_fail++; $display("FAIL oob_read_data1: got %h expected 0", rdata_w[1]); end
        if (err_w[1] !== 1'b1) begin n_fail++; $display("FAIL oob_read_err1: got %b expected 1", err_w[1]); end
        if (err_w[0] !== 1'b0) begin n_fail++; $display("FAIL inrange_read_err0: got %b expected 0", err_w[0]); end
        if (rdata_w[0] !== exp_rdata[0]) begin n_fail++; $display("FAIL inrange_read_data0: got %h expected %h", rdata_w[0], exp_rdata[0]); end
        tick();
        n_checks++;
        if (err_w[1] !== 1'b0) begin n_fail++; $display("FAIL oob_err_width1: got %b expected 0", err_w[1]); end
        calc_we = 1'b1; calc_waddr = 8'd200; calc_wdata = 32'h99;
        tick();
        idle();
        n_checks += 2;
        if (err_w[1] !== 1'b1) begin n_fail++; $display("FAIL oob_write_err1: got %b expected 1", err_w[1]); end
        if (err_w[0] !== 1'b0) begin n_fail++; $display("FAIL inrange_write_err0: got %b expected 0", err_w[0]); end
        raddr = 8'd200;
        tick();
        raddr = 8'd0;
        tick();
        n_checks += 3;
        if (rdata_w[0] !== 32'h99) begin n_fail++; $display("FAIL write200_data0: got %h expected 00000099", rdata_w[0]); end
        if (rdata_w[1] !== '0) begin n_fail++; $display("FAIL oob_readback1: got %h expected 0", rdata_w[1]); end
        if (err_w[1] !== 1'b1) begin n_fail++; $display("FAIL oob_readback_err1: got %b expected 1", err_w[1]); end
        tick();
        n_checks++;
        if (rdata_w[1] !== '0) begin n_fail++; $display("FAIL no_wrap_addr0_1: got %h expected 0", rdata_w[1]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            calc_we    = ($urandom_range(0, 2) == 0);
            calc_waddr = AW'($urandom_range(0, 255));
            calc_wdata = $urandom;
            in_we      = ($urandom_range(0, 2) == 0);
            in_waddr   = AW'($urandom_range(0, 255));
            in_wdata   = $urandom;
            raddr      = (i % 3 == 0) ? calc_waddr : AW'($urandom_range(0, 255));
            clr        = ($urandom_range(0, 199) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks += 3;
                if (ready_w[k] !== (m_left[k] == 0)) begin n_fail++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", k, i, ready_w[k], m_left[k] == 0); end
                if (conf_w[k] !== exp_conf[k]) begin n_fail++; $display("FAIL rand_conflict[%0d] cyc %0d: got %b expected %b", k, i, conf_w[k], exp_conf[k]); end
                if (err_w[k] !== exp_err[k]) begin n_fail++; $display("FAIL rand_addr_err[%0d] cyc %0d: got %b expected %b", k, i, err_w[k], exp_err[k]); end
                if (exp_valid[k]) begin
                    n_checks++;
                    if (rdata_w[k] !== exp_rdata[k]) begin n_fail++; $display("FAIL rand_rdata[%0d] cyc %0d: got %h expected %h", k, i, rdata_w[k], exp_rdata[k]); end
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_read_during_write();
        test_clear();
        test_addr_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_storage_server.md
Name: matrix_storage_server

Overview:
- Shared matrix memory that serves the calculator core's read-request port and write port, plus the input/UI loader's write port.
- Provides a fixed 2-edge registered read pipeline, with two write ports merged by fixed priority.
- Runs a zero-fill sweep after reset and on request.
- Sits between the calculator core, the input FSM and the display reader. It is the responder end of the core's storage interface.

Parameters:
- DATA_W, 32, word width.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_raddr  input  ADDR_W  read address, sampled every rising edge
- o_rdata  output  DATA_W  registered read data
- i_calc_we  input  1  core write enable (high priority)
- i_calc_waddr  input  ADDR_W  core write address
- i_calc_wdata  input  DATA_W  core write data
- i_in_we  input  1  input-FSM write enable (low priority)
- i_in_waddr  input  ADDR_W  input write address
- i_in_wdata  input  DATA_W  input write data
- i_clear  input  1  single-cycle pulse: restart zero-fill sweep
- o_ready  output  1  high when sweep idle and writes accepted
- o_wr_conflict  output  1  one-cycle pulse: input write dropped
- o_addr_err  output  1  one-cycle pulse: access with address ≥ DEPTH

Behaviour:
- Reset values: o_rdata=0, o_ready=0, o_wr_conflict=0, o_addr_err=0, addr_q=0. The sweep FSM enters S_CLEAR with sweep_cnt=0. Array contents are not reset directly; the sweep zeroes them.
- FSM states:
  - S_CLEAR: each cycle write 0 to mem[sweep_cnt] and increment sweep_cnt. When sweep_cnt==DEPTH-1 is written, go to S_READY. Full sweep takes DEPTH cycles.
  - S_READY: o_ready=1, normal operation.
  - i_clear in S_READY: go to S_CLEAR, sweep_cnt=0, o_ready falls next edge.
  - i_clear in S_CLEAR: restart sweep from 0.
  - rst_n low at any time: asynchronous return to S_CLEAR from 0; all in-flight reads and writes are discarded.
- Read pipeline, fixed latency:
  - Edge N: addr_q<=i_raddr.
  - Edge N+1: o_rdata<=mem[addr_q].
  - Data for an address presented before edge N is therefore visible after edge N+1. Reads are unconditional, one per cycle, fully pipelined.
  - Reads during S_CLEAR return current array contents: zero for already-swept words, stale otherwise. Consumers must wait for o_ready.
  - addr_q ≥ DEPTH: o_rdata<=0 and o_addr_err pulses.
- Write arbitration, S_READY only:
  - i_calc_we wins over i_in_we. The winner writes at the same edge.
  - Both asserted in the same cycle: the calc write is performed, the input write is dropped, and o_wr_conflict=1 for one cycle. This applies even when the addresses are equal.
- Writes in S_CLEAR: both ports ignored, no conflict pulse. The sweep write owns the array.
- Write address ≥ DEPTH: write suppressed, o_addr_err pulses. o_addr_err is the OR of read and write errors in the same cycle.
- Read-during-write, same edge and same address: read-first. o_rdata gets the old word; the new word is visible to a read whose addr_q is sampled at or after the write edge.
- No wrap-around: addresses are never taken modulo DEPTH.
- Single clock domain. All outputs are registered except o_ready, which is decoded from the FSM state register.

Test Plan:
- Reset, then idle DEPTH=256 cycles → o_ready rises exactly 256 edges after rst_n release. Reading every address then returns 0 with 2-edge latency.
- Calc write 0x0000_0007 to addr 5, then i_raddr=5 next cycle → o_rdata=7 after edge N+1. Drive addresses 0..24 back-to-back → 25 consecutive correct words, no bubbles.
- Same cycle: calc writes 0xAA and input writes 0xBB, both to addr 10 → mem[10]=0xAA, o_wr_conflict high for 1 cycle. The input port alone writing 0xCC to addr 11 → stored, no pulse.
- addr_q=12 while a write of 0x55 to addr 12 lands on the same edge → o_rdata shows the old value. A read one cycle later shows 0x55.
- i_clear pulse in S_READY with non-zero contents → o_ready low for 256 cycles, writes during the sweep ignored, all words 0 afterwards. rst_n pulsed mid-sweep → sweep restarts from 0.
- With DEPTH=200 overridden: read addr 250 → o_rdata=0 and o_addr_err pulse; write to addr 200 → suppressed and o_addr_err pulse.
